// File: rtl/exu_wb_buffer.sv
// Writeback staging FIFO between execute and regfile/commit; registers the branch
// redirect for the frontend and discards wrong-path beats while the kill window runs.
module exu_wb_buffer #(
  parameter int DEPTH       = 2,
  parameter int KILL_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic [4:0]               in_rd,
  input  logic                     in_need_to_wb,
  input  logic [63:0]              in_result,
  input  logic                     in_redirect_valid,
  input  logic [63:0]              in_redirect_target,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               out_rd,
  output logic                     out_wen,
  output logic [63:0]              out_result,
  output logic                     redirect_valid_q,
  output logic [63:0]              redirect_target_q,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(KILL_CYCLES + 1);

  typedef enum logic {RUN, KILL} state_t;

  state_t          state_reg;
  logic [KW-1:0]   kill_cnt_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [63:0]     mem_pc     [DEPTH];
  logic [31:0]     mem_instr  [DEPTH];
  logic [4:0]      mem_rd     [DEPTH];
  logic            mem_wen    [DEPTH];
  logic [63:0]     mem_result [DEPTH];

  logic            push;
  logic            pop;
  logic [DEPTH-1:0] entry_we;

  // While killing, the buffer swallows beats so execute never stalls on wrong-path work.
  assign in_ready  = (state_reg == KILL) ? 1'b1 : (count_reg < CW'(DEPTH));
  assign push      = in_valid & in_ready & (state_reg == RUN) & ~flush;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready & ~flush;
  assign occupancy = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]     <= '0;
        mem_instr[i]  <= '0;
        mem_rd[i]     <= '0;
        mem_wen[i]    <= 1'b0;
        mem_result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) begin
          mem_pc[i]     <= in_pc;
          mem_instr[i]  <= in_instr;
          mem_rd[i]     <= in_rd;
          mem_wen[i]    <= in_need_to_wb & (in_rd != 5'd0);
          mem_result[i] <= in_result;
        end
      end
    end
  end

  assign out_pc     = mem_pc[rd_ptr_reg];
  assign out_instr  = mem_instr[rd_ptr_reg];
  assign out_rd     = mem_rd[rd_ptr_reg];
  assign out_wen    = mem_wen[rd_ptr_reg];
  assign out_result = mem_result[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= RUN;
      kill_cnt_reg      <= '0;
      rd_ptr_reg        <= '0;
      wr_ptr_reg        <= '0;
      count_reg         <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
    end else if (flush) begin
      // Target is left alone: only reset clears it.
      state_reg        <= RUN;
      kill_cnt_reg     <= '0;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      redirect_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      redirect_valid_q <= push & in_redirect_valid;
      if (push & in_redirect_valid) redirect_target_q <= in_redirect_target;

      case (state_reg)
        RUN: begin
          if (push & in_redirect_valid) begin
            state_reg    <= KILL;
            kill_cnt_reg <= KW'(KILL_CYCLES);
          end
        end
        KILL: begin
          kill_cnt_reg <= kill_cnt_reg - KW'(1);
          if (kill_cnt_reg == KW'(1)) state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_wb_buffer.sv
// Table-driven bench for exu_wb_buffer with a queue scoreboard and a small
// behavioural model of occupancy, kill window and redirect register.
module tb_exu_wb_buffer;

  localparam int DEPTH       = 2;
  localparam int KILL_CYCLES = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic [4:0]  in_rd = '0;
  logic        in_need_to_wb = 1'b0;
  logic [63:0] in_result = '0;
  logic        in_redirect_valid = 1'b0;
  logic [63:0] in_redirect_target = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_result;
  logic        redirect_valid_q;
  logic [63:0] redirect_target_q;
  logic [$clog2(DEPTH):0] occupancy;

  exu_wb_buffer #(.DEPTH(DEPTH), .KILL_CYCLES(KILL_CYCLES)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rd(in_rd),
    .in_need_to_wb(in_need_to_wb), .in_result(in_result),
    .in_redirect_valid(in_redirect_valid), .in_redirect_target(in_redirect_target),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd),
    .out_wen(out_wen), .out_result(out_result),
    .redirect_valid_q(redirect_valid_q), .redirect_target_q(redirect_target_q),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] result;
  } ent_t;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        wb;
    logic [63:0] res;
    logic        redir;
    logic [63:0] tgt;
    logic        fl;
    logic        ord;
    int          exp_occ;  // occupancy after the edge
    logic        exp_rq;   // redirect_valid_q after the edge
  } vec_t;

  ent_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   m_kill = 0;
  logic m_rq = 1'b0;
  logic [63:0] m_tgt = '0;

  function automatic vec_t mk(logic v, logic [4:0] rd, logic wb, logic [63:0] res,
                              logic redir, logic [63:0] tgt, logic fl, logic ord,
                              int exp_occ, logic exp_rq);
    vec_t r;
    r.v = v; r.rd = rd; r.wb = wb; r.res = res; r.redir = redir; r.tgt = tgt;
    r.fl = fl; r.ord = ord; r.exp_occ = exp_occ; r.exp_rq = exp_rq;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("in_ready", 64'(in_ready), (m_kill > 0) ? 64'd1 : 64'(sb.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("redirect_valid_q", 64'(redirect_valid_q), 64'(m_rq));
    chk("redirect_target_q", redirect_target_q, m_tgt);
    if (sb.size() != 0) begin
      chk("out_pc", out_pc, sb[0].pc);
      chk("out_instr", 64'(out_instr), 64'(sb[0].instr));
      chk("out_rd", 64'(out_rd), 64'(sb[0].rd));
      chk("out_wen", 64'(out_wen), 64'(sb[0].wen));
      chk("out_result", out_result, sb[0].result);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    bit   acc;
    bit   pop;
    ent_t e;
    @(negedge clock);
    in_valid           = v.v;
    in_pc              = 64'h8000_0000 + 64'(idx) * 64'd4;
    in_instr           = 32'h0000_0013 + 32'(idx) * 32'h100;
    in_rd              = v.rd;
    in_need_to_wb      = v.wb;
    in_result          = v.res;
    in_redirect_valid  = v.redir;
    in_redirect_target = v.tgt;
    flush              = v.fl;
    out_ready          = v.ord;
    #1;
    check_state();
    acc = v.v && (m_kill == 0) && (sb.size() < DEPTH) && !v.fl;
    pop = (sb.size() != 0) && v.ord && !v.fl;
    if (v.fl) begin
      sb.delete();
      m_kill = 0;
      m_rq   = 1'b0;
      $display("step %0d: flush", idx);
    end else begin
      if (pop) begin
        $display("step %0d: pop  pc=%h result=%h", idx, sb[0].pc, sb[0].result);
        void'(sb.pop_front());
      end
      if (acc) begin
        e.pc = in_pc; e.instr = in_instr; e.rd = v.rd;
        e.wen = v.wb && (v.rd != 5'd0); e.result = v.res;
        sb.push_back(e);
        $display("step %0d: push pc=%h result=%h redir=%0b", idx, e.pc, e.result, v.redir);
      end
      m_rq = acc && v.redir;
      if (m_rq) m_tgt = v.tgt;
      if (m_kill > 0) m_kill--;
      else if (acc && v.redir) m_kill = KILL_CYCLES;
    end
    @(posedge clock);
    #1;
    chk($sformatf("row%0d occupancy", idx), 64'(occupancy), 64'(v.exp_occ));
    chk($sformatf("row%0d redirect_pulse", idx), 64'(redirect_valid_q), 64'(v.exp_rq));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    sb.delete();
    m_kill = 0; m_rq = 1'b0; m_tgt = '0;
    chk("reset occupancy", 64'(occupancy), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset redirect_valid_q", 64'(redirect_valid_q), 64'd0);
    chk("reset redirect_target_q", redirect_target_q, 64'd0);
    chk("reset out_pc", out_pc, 64'd0);
    chk("reset out_result", out_result, 64'd0);
    chk("reset out_wen", 64'(out_wen), 64'd0);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("reset released");
  endtask

  initial begin
    // 1 + 3: streaming with out_ready=1, rd=0 suppresses wen
    tbl.push_back(mk(1, 5'd0, 1, 64'h0000_0000_0000_0A01, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 5'd5, 1, 64'h1111_2222_3333_4444, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 5'd7, 0, 64'h0000_0000_0000_0A03, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 5'd0, 0, 64'h0,                   0, 0, 0, 1, 0, 0));
    // 2: back-pressure, third beat held until space frees
    tbl.push_back(mk(1, 5'd1, 1, 64'h0000_0000_0000_0B01, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 5'd2, 1, 64'h0000_0000_0000_0B02, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 5'd3, 1, 64'h0000_0000_0000_0B03, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 5'd3, 1, 64'h0000_0000_0000_0B03, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 5'd3, 1, 64'h0000_0000_0000_0B03, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 5'd0, 0, 64'h0,                   0, 0, 0, 1, 0, 0));
    // 4: redirect, next beat dropped, following beat pushed
    tbl.push_back(mk(1, 5'd9,  1, 64'h0000_0000_0000_0C01, 1, 64'h8000_0040, 0, 0, 1, 1));
    tbl.push_back(mk(1, 5'd10, 1, 64'h0000_0000_0000_0C02, 0, 0,             0, 0, 1, 0));
    tbl.push_back(mk(1, 5'd11, 1, 64'h0000_0000_0000_0C03, 0, 0,             0, 0, 2, 0));
    tbl.push_back(mk(0, 5'd0,  0, 64'h0,                   0, 0,             0, 1, 1, 0));
    tbl.push_back(mk(0, 5'd0,  0, 64'h0,                   0, 0,             0, 1, 0, 0));
    // 5: redirect while full is ignored
    tbl.push_back(mk(1, 5'd12, 1, 64'h0000_0000_0000_0D01, 0, 0,           0, 0, 1, 0));
    tbl.push_back(mk(1, 5'd13, 1, 64'h0000_0000_0000_0D02, 0, 0,           0, 0, 2, 0));
    tbl.push_back(mk(1, 5'd14, 1, 64'h0000_0000_0000_0D03, 1, 64'h1234,    0, 0, 2, 0));
    tbl.push_back(mk(0, 5'd0,  0, 64'h0,                   0, 0,           0, 1, 1, 0));
    // 6: flush with push+pop pending; flush also masks a redirect
    tbl.push_back(mk(1, 5'd15, 1, 64'h0000_0000_0000_0E01, 0, 0,           0, 0, 2, 0));
    tbl.push_back(mk(1, 5'd16, 1, 64'h0000_0000_0000_0E02, 0, 0,           1, 1, 0, 0));
    tbl.push_back(mk(0, 5'd0,  0, 64'h0,                   0, 0,           0, 0, 0, 0));
    tbl.push_back(mk(1, 5'd17, 1, 64'h0000_0000_0000_0E03, 1, 64'h5555,    1, 0, 0, 0));
    tbl.push_back(mk(1, 5'd18, 1, 64'h0000_0000_0000_0E04, 0, 0,           0, 1, 1, 0));
    tbl.push_back(mk(0, 5'd0,  0, 64'h0,                   0, 0,           0, 1, 0, 0));
    // redirect captured, then reset mid-operation must clear the target
    tbl.push_back(mk(1, 5'd19, 1, 64'h0000_0000_0000_0F01, 1, 64'hDEAD_BEEF, 0, 0, 1, 1));
    tbl.push_back(mk(0, 5'd0,  0, 64'h0,                   0, 0,             0, 0, 1, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    chk("target before reset", redirect_target_q, 64'hDEAD_BEEF);
    do_reset();
    step(mk(1, 5'd20, 1, 64'h0000_0000_0000_1001, 0, 0, 0, 0, 1, 0), 100);
    step(mk(0, 5'd0,  0, 64'h0,                   0, 0, 0, 1, 0, 0), 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
